snow64_mem_arbiter: RTL and testbench
=====================================

# snow64_mem_arbiter

Shares the single external memory port between the instruction cache (read-only, 256-bit line fills) and the data LAR file (256-bit line reads and write-backs). The block captures one-cycle request pulses from each side and issues one memory transaction at a time. It routes each response back to its originator as a one-cycle valid pulse. It sits between both caches and the memory controller.

## Interface
- No parameters. Widths: address 64 bits (`MSB_POS__SNOW64_CPU_ADDR` = 63); line 256 bits (`MSB_POS__SNOW64_LAR_FILE_DATA` = 255).
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_icache_req  in  1  one-cycle instruction-cache read request pulse
- in_icache_addr  in  64  line address, sampled with req
- out_icache_valid  out  1  one-cycle response pulse
- out_icache_data  out  256  fill data; holds last value
- in_dcache_req  in  1  one-cycle data-side request pulse
- in_dcache_write  in  1  1 = write-back, 0 = read; sampled with req
- in_dcache_addr  in  64  line address
- in_dcache_data  in  256  write-back data
- out_dcache_valid  out  1  one-cycle response pulse (read data or write acknowledge)
- out_dcache_data  out  256  read data; holds last value; unchanged on write ack
- out_mem_req  out  1  one-cycle memory request pulse
- out_mem_write  out  1  transaction direction
- out_mem_addr, out_mem_data  out  64, 256  held from issue until next issue
- in_mem_valid  in  1  one-cycle memory completion pulse
- in_mem_data  in  256  read data, valid with in_mem_valid

## Operation
- One pending slot per requester: pending flag, addr, write, data. A req captures into its slot when the slot is empty.
- A req while own slot pending is a protocol violation: ignored, slot unchanged.
- FSM states:
  - IDLE: if any slot pending or req arriving, go to ISSUE.
  - ISSUE: out_mem_req = 1 for exactly one cycle, then WAIT.
  - WAIT: on in_mem_valid, route the response, clear the winner's slot, then go to ISSUE if the other slot is pending (or req arriving), else IDLE.
- Winner is chosen on entry to ISSUE. Winner id and the out_mem_* fields are registered on that edge.
- in_mem_valid outside WAIT is ignored. Memory latency is at least 1 cycle after the ISSUE cycle.
- All outputs are registered. Reset value of every output is 0. FSM resets to IDLE; slots reset empty.
- Asserting reset mid-transaction abandons the transaction. The memory controller shares rst_n, so no stale response is returned.

## Timing
- Req in cycle 0 with FSM IDLE: out_mem_req high in cycle 1.
- in_mem_valid in cycle K: out_x_valid and out_x_data in cycle K+1.
- Back-to-back: next out_mem_req also in cycle K+1, if another slot is pending.
- Req arriving on the same edge as in_mem_valid is captured and eligible for that arbitration.
- Minimum turnaround for a requester: 3 cycles (req, ISSUE, valid at earliest cycle 2, response cycle 3).

## Configuration
- `SNOW64_MEM_ARBITER_FAIR_EN` defined:
  - Round-robin arbitration: on contention, the side not granted last wins.
  - Last-grant register resets to icache, so dcache wins the first contention.
- Undefined: fixed priority, dcache always wins contention; no last-grant register.

## Structure
- Package PkgSnow64MemArbiter holds:
  - State enum: IDLE, ISSUE, WAIT.
  - Requester enum: ICACHE = 0, DCACHE = 1.
  - Packed slot struct {pending, write, addr, data}.
  - Port structs PortIn_MemArbiter / PortOut_MemArbiter.
- One sub-module, snow64_mem_req_slot: capture/hold/clear of a single request, instantiated twice. Icache instance has write tied to 0.

## Test plan
- Single icache read of addr 0x1000, memory returns 0xAA.. after 3 cycles -> out_mem_req cycle 1, write = 0, out_icache_valid with 0xAA.. exactly once, one cycle after in_mem_valid.
- Dcache write-back addr 0x2000, data 0x55.. -> out_mem_write = 1, addr/data held through WAIT; out_dcache_valid pulse; out_dcache_data unchanged.
- Both req in same cycle:
  - Fair build: dcache then icache; with repeated contention, grants alternate.
  - Unfair build: dcache always first.
- Icache re-req with addr 0x3000 while 0x1000 pending -> ignored, memory sees only 0x1000.
- rst_n low during WAIT -> all outputs 0 asynchronously; no valid pulse after release; a fresh req then completes normally.
- Spurious in_mem_valid in IDLE -> no output valid, FSM stays IDLE.

Source files
------------

// File: rtl/PkgSnow64MemArbiter.sv
// Types shared by the instruction/data memory arbiter and its request slots.
package PkgSnow64MemArbiter;
  localparam int MSB_POS__SNOW64_CPU_ADDR      = 63;
  localparam int MSB_POS__SNOW64_LAR_FILE_DATA = 255;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} State;

  typedef enum logic {ICACHE = 1'b0, DCACHE = 1'b1} Requester;

  typedef struct packed {
    logic                                   pending;
    logic                                   write;
    logic [MSB_POS__SNOW64_CPU_ADDR:0]      addr;
    logic [MSB_POS__SNOW64_LAR_FILE_DATA:0] data;
  } SlotReq;

  typedef struct packed {
    logic                                   icache_req;
    logic [MSB_POS__SNOW64_CPU_ADDR:0]      icache_addr;
    logic                                   dcache_req;
    logic                                   dcache_write;
    logic [MSB_POS__SNOW64_CPU_ADDR:0]      dcache_addr;
    logic [MSB_POS__SNOW64_LAR_FILE_DATA:0] dcache_data;
    logic                                   mem_valid;
    logic [MSB_POS__SNOW64_LAR_FILE_DATA:0] mem_data;
  } PortIn_MemArbiter;

  typedef struct packed {
    logic                                   icache_valid;
    logic [MSB_POS__SNOW64_LAR_FILE_DATA:0] icache_data;
    logic                                   dcache_valid;
    logic [MSB_POS__SNOW64_LAR_FILE_DATA:0] dcache_data;
    logic                                   mem_req;
    logic                                   mem_write;
    logic [MSB_POS__SNOW64_CPU_ADDR:0]      mem_addr;
    logic [MSB_POS__SNOW64_LAR_FILE_DATA:0] mem_data;
  } PortOut_MemArbiter;
endpackage

// File: rtl/snow64_mem_req_slot.sv
// Single pending-request holder: captures a request pulse when empty and
// keeps it until the arbiter retires it.
module snow64_mem_req_slot
  import PkgSnow64MemArbiter::*;
(
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   req,
  input  logic                                   write,
  input  logic [MSB_POS__SNOW64_CPU_ADDR:0]      addr,
  input  logic [MSB_POS__SNOW64_LAR_FILE_DATA:0] data,
  input  logic                                   clear,
  output SlotReq                                 slot
);
  // A request while already pending is a protocol violation and is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (clear) begin
      slot.pending <= 1'b0;
    end else if (req && !slot.pending) begin
      slot.pending <= 1'b1;
      slot.write   <= write;
      slot.addr    <= addr;
      slot.data    <= data;
    end
  end
endmodule

// File: rtl/snow64_mem_arbiter.sv
// Shares one memory port between the icache and the data LAR file.
// Define SNOW64_MEM_ARBITER_FAIR_EN for round-robin; default is dcache priority.
module snow64_mem_arbiter
  import PkgSnow64MemArbiter::*;
(
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_icache_req,
  input  logic [MSB_POS__SNOW64_CPU_ADDR:0]      in_icache_addr,
  output logic                                   out_icache_valid,
  output logic [MSB_POS__SNOW64_LAR_FILE_DATA:0] out_icache_data,
  input  logic                                   in_dcache_req,
  input  logic                                   in_dcache_write,
  input  logic [MSB_POS__SNOW64_CPU_ADDR:0]      in_dcache_addr,
  input  logic [MSB_POS__SNOW64_LAR_FILE_DATA:0] in_dcache_data,
  output logic                                   out_dcache_valid,
  output logic [MSB_POS__SNOW64_LAR_FILE_DATA:0] out_dcache_data,
  output logic                                   out_mem_req,
  output logic                                   out_mem_write,
  output logic [MSB_POS__SNOW64_CPU_ADDR:0]      out_mem_addr,
  output logic [MSB_POS__SNOW64_LAR_FILE_DATA:0] out_mem_data,
  input  logic                                   in_mem_valid,
  input  logic [MSB_POS__SNOW64_LAR_FILE_DATA:0] in_mem_data
);
  State              state;
  Requester          winner, pick;
  PortOut_MemArbiter port_out;
  SlotReq            slot_i, slot_d, eff_i, eff_d, pick_req;
  logic              completing, clear_i, clear_d, cand_i, cand_d, go_issue;
`ifdef SNOW64_MEM_ARBITER_FAIR_EN
  Requester          last_grant;
`endif

  assign completing = (state == WAIT) && in_mem_valid;
  assign clear_i    = completing && (winner == ICACHE);
  assign clear_d    = completing && (winner == DCACHE);

  snow64_mem_req_slot u_slot_icache (
    .clk(clk), .rst_n(rst_n), .req(in_icache_req), .write(1'b0),
    .addr(in_icache_addr), .data('0), .clear(clear_i), .slot(slot_i)
  );

  snow64_mem_req_slot u_slot_dcache (
    .clk(clk), .rst_n(rst_n), .req(in_dcache_req), .write(in_dcache_write),
    .addr(in_dcache_addr), .data(in_dcache_data), .clear(clear_d), .slot(slot_d)
  );

  // A request arriving this edge is eligible as if it were already in its slot.
  always_comb begin
    eff_i = slot_i;
    if (!slot_i.pending) begin
      eff_i.pending = in_icache_req;
      eff_i.write   = 1'b0;
      eff_i.addr    = in_icache_addr;
      eff_i.data    = '0;
    end
    eff_d = slot_d;
    if (!slot_d.pending) begin
      eff_d.pending = in_dcache_req;
      eff_d.write   = in_dcache_write;
      eff_d.addr    = in_dcache_addr;
      eff_d.data    = in_dcache_data;
    end
  end

  // The side being retired this edge cannot contend again.
  assign cand_i   = eff_i.pending && !clear_i;
  assign cand_d   = eff_d.pending && !clear_d;
  assign go_issue = ((state == IDLE) || completing) && (cand_i || cand_d);

`ifdef SNOW64_MEM_ARBITER_FAIR_EN
  assign pick = (cand_d && (!cand_i || (last_grant == ICACHE))) ? DCACHE : ICACHE;
`else
  assign pick = cand_d ? DCACHE : ICACHE;
`endif
  assign pick_req = (pick == DCACHE) ? eff_d : eff_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      winner   <= ICACHE;
      port_out <= '0;
`ifdef SNOW64_MEM_ARBITER_FAIR_EN
      last_grant <= ICACHE;
`endif
    end else begin
      port_out.mem_req      <= 1'b0;
      port_out.icache_valid <= 1'b0;
      port_out.dcache_valid <= 1'b0;
      case (state)
        IDLE:  if (go_issue) state <= ISSUE;
        ISSUE: state <= WAIT;
        WAIT: begin
          if (in_mem_valid) begin
            if (winner == ICACHE) begin
              port_out.icache_valid <= 1'b1;
              port_out.icache_data  <= in_mem_data;
            end else begin
              port_out.dcache_valid <= 1'b1;
              // A write-back ack leaves the last read data visible.
              if (!port_out.mem_write) port_out.dcache_data <= in_mem_data;
            end
            state <= go_issue ? ISSUE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (go_issue) begin
        winner             <= pick;
        port_out.mem_req   <= 1'b1;
        port_out.mem_write <= pick_req.write;
        port_out.mem_addr  <= pick_req.addr;
        port_out.mem_data  <= pick_req.data;
`ifdef SNOW64_MEM_ARBITER_FAIR_EN
        last_grant <= pick;
`endif
      end
    end
  end

  assign out_icache_valid = port_out.icache_valid;
  assign out_icache_data  = port_out.icache_data;
  assign out_dcache_valid = port_out.dcache_valid;
  assign out_dcache_data  = port_out.dcache_data;
  assign out_mem_req      = port_out.mem_req;
  assign out_mem_write    = port_out.mem_write;
  assign out_mem_addr     = port_out.mem_addr;
  assign out_mem_data     = port_out.mem_data;
endmodule

// File: tb/tb_snow64_mem_arbiter.sv
// Bench for snow64_mem_arbiter: directed vectors, corner sequences and a
// randomized run against a transaction-level model of the arbiter.
module tb_snow64_mem_arbiter;
`ifdef SNOW64_MEM_ARBITER_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_icache_req = 1'b0, in_dcache_req = 1'b0, in_dcache_write = 1'b0;
  logic [63:0]  in_icache_addr = '0, in_dcache_addr = '0;
  logic [255:0] in_dcache_data = '0, in_mem_data = '0;
  logic         in_mem_valid = 1'b0;
  logic         out_icache_valid, out_dcache_valid, out_mem_req, out_mem_write;
  logic [255:0] out_icache_data, out_dcache_data, out_mem_data;
  logic [63:0]  out_mem_addr;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  snow64_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .in_icache_req(in_icache_req), .in_icache_addr(in_icache_addr),
    .out_icache_valid(out_icache_valid), .out_icache_data(out_icache_data),
    .in_dcache_req(in_dcache_req), .in_dcache_write(in_dcache_write),
    .in_dcache_addr(in_dcache_addr), .in_dcache_data(in_dcache_data),
    .out_dcache_valid(out_dcache_valid), .out_dcache_data(out_dcache_data),
    .out_mem_req(out_mem_req), .out_mem_write(out_mem_write),
    .out_mem_addr(out_mem_addr), .out_mem_data(out_mem_data),
    .in_mem_valid(in_mem_valid), .in_mem_data(in_mem_data)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkw(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic check_all_zero(input string tag);
    check1({tag, "_ivalid"}, out_icache_valid, 1'b0);
    check1({tag, "_dvalid"}, out_dcache_valid, 1'b0);
    check1({tag, "_mem_req"}, out_mem_req, 1'b0);
    check1({tag, "_mem_write"}, out_mem_write, 1'b0);
    check64({tag, "_mem_addr"}, out_mem_addr, 64'h0);
    checkw({tag, "_mem_data"}, out_mem_data, 256'h0);
    checkw({tag, "_idata"}, out_icache_data, 256'h0);
    checkw({tag, "_ddata"}, out_dcache_data, 256'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_icache_req = 1'b0;
    in_dcache_req = 1'b0;
    in_mem_valid  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic         side;        // 0 icache, 1 dcache
    logic         write;
    logic [63:0]  addr;
    logic [255:0] wdata;
    int           lat;         // cycles from ISSUE to in_mem_valid
    logic [255:0] rdata;
    logic         exp_write;
    logic [255:0] exp_mem_data;
    logic [255:0] exp_i_data;
    logic [255:0] exp_d_data;
  } vec_t;

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    if (v.side) begin
      in_dcache_req   = 1'b1;
      in_dcache_write = v.write;
      in_dcache_addr  = v.addr;
      in_dcache_data  = v.wdata;
    end else begin
      in_icache_req  = 1'b1;
      in_icache_addr = v.addr;
    end
    @(negedge clk);
    in_icache_req = 1'b0;
    in_dcache_req = 1'b0;
    check1("issue_req", out_mem_req, 1'b1);
    check1("issue_write", out_mem_write, v.exp_write);
    check64("issue_addr", out_mem_addr, v.addr);
    checkw("issue_data", out_mem_data, v.exp_mem_data);
    for (int c = 2; c <= v.lat + 1; c++) begin
      @(negedge clk);
      check1("wait_req", out_mem_req, 1'b0);
      check64("hold_addr", out_mem_addr, v.addr);
      checkw("hold_data", out_mem_data, v.exp_mem_data);
      check1("early_valid", out_icache_valid | out_dcache_valid, 1'b0);
      if (c == v.lat + 1) begin
        in_mem_valid = 1'b1;
        in_mem_data  = v.rdata;
      end
    end
    @(negedge clk);
    in_mem_valid = 1'b0;
    in_mem_data  = rand256();
    check1("resp_ivalid", out_icache_valid, !v.side);
    check1("resp_dvalid", out_dcache_valid, v.side);
    checkw("resp_idata", out_icache_data, v.exp_i_data);
    checkw("resp_ddata", out_dcache_data, v.exp_d_data);
    @(negedge clk);
    check1("once_ivalid", out_icache_valid, 1'b0);
    check1("once_dvalid", out_dcache_valid, 1'b0);
    check1("after_req", out_mem_req, 1'b0);
    $display("[TB] txn side=%0d write=%0d addr=%h lat=%0d", v.side, v.write, v.addr, v.lat);
  endtask

  // Both sides request on the same cycle; d_first tells which must win.
  task automatic contend(input logic d_first, input logic [63:0] ia, input logic [63:0] da,
                         input logic [255:0] r1, input logic [255:0] r2);
    @(negedge clk);
    in_icache_req   = 1'b1;
    in_icache_addr  = ia;
    in_dcache_req   = 1'b1;
    in_dcache_write = 1'b0;
    in_dcache_addr  = da;
    @(negedge clk);
    in_icache_req = 1'b0;
    in_dcache_req = 1'b0;
    check1("cont_req1", out_mem_req, 1'b1);
    check64("cont_addr1", out_mem_addr, d_first ? da : ia);
    @(negedge clk);
    in_mem_valid = 1'b1;
    in_mem_data  = r1;
    @(negedge clk);
    in_mem_valid = 1'b0;
    check1("cont_first_dvalid", out_dcache_valid, d_first);
    check1("cont_first_ivalid", out_icache_valid, !d_first);
    checkw("cont_first_data", d_first ? out_dcache_data : out_icache_data, r1);
    check1("cont_b2b_req", out_mem_req, 1'b1);
    check64("cont_addr2", out_mem_addr, d_first ? ia : da);
    @(negedge clk);
    in_mem_valid = 1'b1;
    in_mem_data  = r2;
    @(negedge clk);
    in_mem_valid = 1'b0;
    check1("cont_second_dvalid", out_dcache_valid, !d_first);
    check1("cont_second_ivalid", out_icache_valid, d_first);
    checkw("cont_second_data", d_first ? out_icache_data : out_dcache_data, r2);
    check1("cont_end_req", out_mem_req, 1'b0);
    $display("[TB] contention grant order: %s", d_first ? "dcache,icache" : "icache,dcache");
  endtask

  task automatic random_phase(input int ncycles);
    bit oi = 0, oi_iss = 0, od = 0, od_iss = 0, od_w = 0;
    bit inflight = 0, infl_d = 0, resp = 0, last_d = 0, ever = 0, just, stim, done = 0;
    bit exp_vi, exp_vd, cand_i, cand_d, exp_req, pick_d, held_w = 0;
    logic [63:0]  oi_a = '0, od_a = '0, held_a = '0;
    logic [255:0] od_data = '0, held_data = '0, m_i = '0, m_d = '0;
    int cd = 0, issues = 0;
    for (int n = 0; n < ncycles + 300; n++) begin
      @(negedge clk);
      stim = (n < ncycles);
      // Requests sampled at the last edge join their side's queue if it is free.
      if (in_icache_req && !oi) begin oi = 1; oi_iss = 0; oi_a = in_icache_addr; end
      if (in_dcache_req && !od) begin
        od = 1; od_iss = 0; od_w = in_dcache_write; od_a = in_dcache_addr; od_data = in_dcache_data;
      end
      exp_vi = 0;
      exp_vd = 0;
      if (resp) begin
        if (infl_d) begin exp_vd = 1; if (!od_w) m_d = in_mem_data; od = 0; end
        else begin exp_vi = 1; m_i = in_mem_data; oi = 0; end
        inflight = 0;
      end
      check1("rnd_ivalid", out_icache_valid, exp_vi);
      check1("rnd_dvalid", out_dcache_valid, exp_vd);
      checkw("rnd_idata", out_icache_data, m_i);
      checkw("rnd_ddata", out_dcache_data, m_d);
      cand_i  = oi && !oi_iss;
      cand_d  = od && !od_iss;
      exp_req = !inflight && (cand_i || cand_d);
      check1("rnd_mem_req", out_mem_req, exp_req);
      just = 0;
      if (out_mem_req && exp_req) begin
        pick_d    = cand_d && (!cand_i || !FAIR || !last_d);
        last_d    = pick_d;
        infl_d    = pick_d;
        inflight  = 1;
        just      = 1;
        ever      = 1;
        issues++;
        cd        = $urandom_range(1, 4);
        held_w    = pick_d ? od_w : 1'b0;
        held_a    = pick_d ? od_a : oi_a;
        held_data = pick_d ? od_data : 256'h0;
        if (pick_d) od_iss = 1; else oi_iss = 1;
        check1("rnd_issue_write", out_mem_write, held_w);
        check64("rnd_issue_addr", out_mem_addr, held_a);
        checkw("rnd_issue_data", out_mem_data, held_data);
      end else if (ever) begin
        check1("rnd_hold_write", out_mem_write, held_w);
        check64("rnd_hold_addr", out_mem_addr, held_a);
        checkw("rnd_hold_data", out_mem_data, held_data);
      end
      if (!stim && !oi && !od && !inflight) begin
        done = 1;
        in_icache_req = 1'b0;
        in_dcache_req = 1'b0;
        in_mem_valid  = 1'b0;
        break;
      end
      // Memory side: real responses after the drawn latency, stray pulses while idle.
      resp         = 0;
      in_mem_valid = 1'b0;
      in_mem_data  = rand256();
      if (inflight && !just) begin
        cd--;
        if (cd == 0) begin in_mem_valid = 1'b1; resp = 1; end
      end else if (!inflight && ($urandom_range(0, 15) == 0)) begin
        in_mem_valid = 1'b1;
      end
      in_icache_req   = stim && ($urandom_range(0, 3) == 0);
      in_icache_addr  = rand64();
      in_dcache_req   = stim && ($urandom_range(0, 3) == 0);
      in_dcache_write = 1'($urandom_range(0, 1));
      in_dcache_addr  = rand64();
      in_dcache_data  = rand256();
    end
    check1("rnd_drained", done, 1'b1);
    $display("[TB] random phase: %0d memory transactions", issues);
  endtask

  vec_t vecs[4];
  vec_t v;

  initial begin
    vecs[0] = '{side: 1'b0, write: 1'b0, addr: 64'h1000, wdata: 256'h0, lat: 3,
                rdata: {32{8'hAA}}, exp_write: 1'b0, exp_mem_data: 256'h0,
                exp_i_data: {32{8'hAA}}, exp_d_data: 256'h0};
    vecs[1] = '{side: 1'b1, write: 1'b0, addr: 64'h2040, wdata: {32{8'h99}}, lat: 1,
                rdata: {32{8'h3C}}, exp_write: 1'b0, exp_mem_data: {32{8'h99}},
                exp_i_data: {32{8'hAA}}, exp_d_data: {32{8'h3C}}};
    vecs[2] = '{side: 1'b1, write: 1'b1, addr: 64'h2000, wdata: {32{8'h55}}, lat: 2,
                rdata: {32{8'hFF}}, exp_write: 1'b1, exp_mem_data: {32{8'h55}},
                exp_i_data: {32{8'hAA}}, exp_d_data: {32{8'h3C}}};
    vecs[3] = '{side: 1'b0, write: 1'b0, addr: 64'hFFFF_FFFF_FFFF_FFE0, wdata: 256'h0, lat: 5,
                rdata: {8{32'h0123_4567}}, exp_write: 1'b0, exp_mem_data: 256'h0,
                exp_i_data: {8{32'h0123_4567}}, exp_d_data: {32{8'h3C}}};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Last grant is icache here, so dcache wins in either build.
    contend(1'b1, 64'h4000, 64'h5000, {32{8'hC1}}, {32{8'hC2}});
    v = '{side: 1'b1, write: 1'b1, addr: 64'h8000, wdata: {32{8'h77}}, lat: 2,
          rdata: {32{8'hEE}}, exp_write: 1'b1, exp_mem_data: {32{8'h77}},
          exp_i_data: {32{8'hC2}}, exp_d_data: {32{8'hC1}}};
    run_vec(v);
    // Dcache was granted last: round-robin hands this contention to icache.
    contend(FAIR ? 1'b0 : 1'b1, 64'h4100, 64'h5100, {32{8'hD3}}, {32{8'hD4}});

    // Re-request from icache while its first request is outstanding.
    @(negedge clk);
    in_icache_req  = 1'b1;
    in_icache_addr = 64'h1000;
    @(negedge clk);
    in_icache_addr = 64'h3000;
    check1("rereq_issue", out_mem_req, 1'b1);
    check64("rereq_addr", out_mem_addr, 64'h1000);
    @(negedge clk);
    in_icache_req = 1'b0;
    in_mem_valid  = 1'b1;
    in_mem_data   = {32{8'hB7}};
    @(negedge clk);
    in_mem_valid = 1'b0;
    check1("rereq_ivalid", out_icache_valid, 1'b1);
    checkw("rereq_idata", out_icache_data, {32{8'hB7}});
    repeat (4) begin
      @(negedge clk);
      check1("rereq_no_issue", out_mem_req, 1'b0);
      check1("rereq_no_valid", out_icache_valid, 1'b0);
    end
    $display("[TB] txn icache re-request dropped");

    // Reset in the middle of a WAIT.
    @(negedge clk);
    in_dcache_req   = 1'b1;
    in_dcache_write = 1'b0;
    in_dcache_addr  = 64'h6000;
    @(negedge clk);
    in_dcache_req = 1'b0;
    check1("rstw_issue", out_mem_req, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("rstw_async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check1("rstw_no_ivalid", out_icache_valid, 1'b0);
      check1("rstw_no_dvalid", out_dcache_valid, 1'b0);
      check1("rstw_no_req", out_mem_req, 1'b0);
    end
    $display("[TB] txn reset during WAIT");
    v = '{side: 1'b0, write: 1'b0, addr: 64'h7000, wdata: 256'h0, lat: 2,
          rdata: {32{8'h5A}}, exp_write: 1'b0, exp_mem_data: 256'h0,
          exp_i_data: {32{8'h5A}}, exp_d_data: 256'h0};
    run_vec(v);

    // Stray completion pulse while idle.
    @(negedge clk);
    in_mem_valid = 1'b1;
    in_mem_data  = rand256();
    @(negedge clk);
    in_mem_valid = 1'b0;
    check1("spur_ivalid", out_icache_valid, 1'b0);
    check1("spur_dvalid", out_dcache_valid, 1'b0);
    check1("spur_req", out_mem_req, 1'b0);
    @(negedge clk);
    check1("spur_still_idle", out_mem_req, 1'b0);
    checkw("spur_idata", out_icache_data, {32{8'h5A}});
    $display("[TB] txn spurious in_mem_valid in IDLE");

    do_reset();
    random_phase(3000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
